fpmult_result_buffer: RTL and testbench

- Downstream stage of the pipelined DSP48E1 floating-point multiplier.
- Captures each single-precision product (Z) and its 5-bit exception flags into a small FIFO, because the multiplier cannot stall.
- Presents results to the consumer over a valid/ready handshake.
- Keeps IEEE-style sticky exception flags, plus an almost-full signal the operand issuer uses to throttle.

---
 rtl/fpmult_pkg.sv | 22 ++
 rtl/fpmult_result_fifo.sv | 44 ++++
 rtl/fpmult_result_buffer.sv | 88 ++++++++
 tb/tb_fpmult_result_buffer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fpmult_pkg.sv
// Shared fp32 word type and exception-flag bit positions used by the
// floating-point multiplier and its result buffer.
package fpmult_pkg;

  localparam int FP32_W = 32;
  localparam int FLAG_W = 5;

  typedef logic [FP32_W-1:0] fp32_t;
  typedef logic [FLAG_W-1:0] fpflags_t;

  localparam int FLAG_NAN  = 4;
  localparam int FLAG_INF  = 3;
  localparam int FLAG_ZERO = 2;
  localparam int FLAG_OVF  = 1;
  localparam int FLAG_UNF  = 0;

  typedef struct packed {
    fp32_t    z;
    fpflags_t flags;
  } fpresult_t;

endpackage

// File: rtl/fpmult_result_fifo.sv
// Circular buffer holding multiplier results; the caller guarantees it never
// pushes into a full buffer without a pop in the same cycle.
module fpmult_result_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int WIDTH  = 37
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic [ADDR_W:0]   count
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  // Payload storage carries no reset; only occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fpmult_result_buffer.sv
// Non-stalling result buffer behind the fp multiplier: FIFO, sticky flags,
// overrun and almost-full throttle. Optional zero-latency path: FPMULT_RESULT_BYPASS_EN.
module fpmult_result_buffer
  import fpmult_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 3,
  parameter int AF_MARGIN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [31:0]       in_z,
  input  logic [4:0]        in_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_z,
  output logic [4:0]        out_flags,
  output logic [ADDR_W:0]   count,
  output logic              almost_full,
  output logic [4:0]        sticky_flags,
  input  logic              sticky_clr,
  output logic              overrun
);

  localparam int PW    = FP32_W + FLAG_W;
  localparam int AF_TH = (DEPTH > AF_MARGIN) ? (DEPTH - AF_MARGIN) : 0;

  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          wr_en;
  logic          byp_take;
  logic          accepted;
  logic          drop;
  logic [PW-1:0] head;
  fp32_t         head_z;
  fpflags_t      head_flags;

  fpmult_result_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (PW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data ({in_z, in_flags}),
    .rd_en   (pop),
    .rd_data (head),
    .count   (count)
  );

  assign head_z     = head[PW-1:FLAG_W];
  assign head_flags = head[FLAG_W-1:0];
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (ADDR_W+1)'(DEPTH));

`ifdef FPMULT_RESULT_BYPASS_EN
  // An empty buffer forwards the live result; if taken now it is never stored.
  assign byp_take  = fifo_empty & in_valid & out_ready;
  assign out_valid = ~fifo_empty | in_valid;
  assign out_z     = fifo_empty ? in_z : head_z;
  assign out_flags = fifo_empty ? in_flags : head_flags;
`else
  assign byp_take  = 1'b0;
  assign out_valid = ~fifo_empty;
  assign out_z     = head_z;
  assign out_flags = head_flags;
`endif

  assign pop         = ~fifo_empty & out_ready;
  assign wr_en       = in_valid & ~byp_take & (~fifo_full | pop);
  assign accepted    = wr_en | byp_take;
  assign drop        = in_valid & fifo_full & ~pop;
  assign almost_full = (count >= (ADDR_W+1)'(AF_TH));

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_flags <= '0;
      overrun      <= 1'b0;
    end else begin
      sticky_flags <= (sticky_clr ? 5'b0 : sticky_flags) | (accepted ? in_flags : 5'b0);
      if (drop) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fpmult_result_buffer.sv
// Directed-plus-random bench for fpmult_result_buffer against a queue-based
// reference model; follows FPMULT_RESULT_BYPASS_EN when defined.
module tb_fpmult_result_buffer;
  import fpmult_pkg::*;

  localparam int DEPTH     = 8;
  localparam int ADDR_W    = 3;
  localparam int AF_MARGIN = 4;
`ifdef FPMULT_RESULT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic [31:0]     in_z;
  logic [4:0]      in_flags;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_z;
  logic [4:0]      out_flags;
  logic [ADDR_W:0] count;
  logic            almost_full;
  logic [4:0]      sticky_flags;
  logic            sticky_clr;
  logic            overrun;

  fpmult_result_buffer #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .AF_MARGIN (AF_MARGIN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_z         (in_z),
    .in_flags     (in_flags),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_z        (out_z),
    .out_flags    (out_flags),
    .count        (count),
    .almost_full  (almost_full),
    .sticky_flags (sticky_flags),
    .sticky_clr   (sticky_clr),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] z;
    logic [4:0]  f;
  } ent_t;

  ent_t       q[$];
  logic [4:0] m_sticky;
  logic       m_ovr;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, compare outputs with the model, then advance the model.
  task automatic step(input logic iv, input logic [31:0] z, input logic [4:0] f,
                      input logic rdy, input logic clr);
    bit   exp_valid;
    bit   empty;
    bit   byp_consume;
    bit   acc;
    ent_t e;
    @(negedge clk);
    rst = 1'b0; in_valid = iv; in_z = z; in_flags = f; out_ready = rdy; sticky_clr = clr;
    #1;
    empty     = (q.size() == 0);
    exp_valid = !empty || (BYP && iv);
    chk("out_valid", 64'(out_valid), 64'(exp_valid));
    chk("count", 64'(count), 64'(q.size()));
    chk("almost_full", 64'(almost_full), 64'(q.size() >= DEPTH - AF_MARGIN));
    chk("sticky", 64'(sticky_flags), 64'(m_sticky));
    chk("overrun", 64'(overrun), 64'(m_ovr));
    if (exp_valid) begin
      if (!empty) begin
        e = q[0];
      end else begin
        e.z = z;
        e.f = f;
      end
      chk("out_z", 64'(out_z), 64'(e.z));
      chk("out_flags", 64'(out_flags), 64'(e.f));
    end
    @(posedge clk);
    byp_consume = BYP && empty && iv && rdy;
    acc = byp_consume;
    if (!empty && rdy) void'(q.pop_front());
    if (iv && !byp_consume) begin
      if (q.size() < DEPTH) begin
        e.z = z;
        e.f = f;
        q.push_back(e);
        acc = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end
    m_sticky = (clr ? 5'b0 : m_sticky) | (acc ? f : 5'b0);
    #1;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_z = '0; in_flags = '0; out_ready = 1'b0; sticky_clr = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    q.delete();
    m_sticky = '0;
    m_ovr    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_z = '0; in_flags = '0; out_ready = 1'b0; sticky_clr = 1'b0;
    m_sticky = '0; m_ovr = 1'b0;

    // Reset state
    do_reset(2);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_af", 64'(almost_full), 64'd0);
    step(1'b0, 32'h0, 5'h0, 1'b0, 1'b0);

    // Basic single result, 1.0 * 1.0
    step(1'b1, 32'h3F80_0000, 5'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 5'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 5'h0, 1'b1, 1'b0);
    chk("basic_count", 64'(count), 64'd0);

    // Fill past capacity, then drain in order
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, 32'h4000_0000, 5'h0, 1'b0, 1'b0);
      if (i == 3) chk("af_low_at3", 64'(almost_full), 64'd0);
      if (i == 4) chk("af_high_at4", 64'(almost_full), 64'd1);
    end
    chk("fill_count", 64'(count), 64'd8);
    chk("fill_overrun", 64'(overrun), 64'd1);
    repeat (8) step(1'b0, 32'h0, 5'h0, 1'b1, 1'b0);
    chk("drain_count", 64'(count), 64'd0);

    // Full buffer with simultaneous pop and push
    do_reset(1);
    for (int i = 0; i < 8; i++) step(1'b1, 32'h4100_0000 + 32'(i), 5'h0, 1'b0, 1'b0);
    step(1'b1, 32'h4040_0000, 5'h0, 1'b1, 1'b0);
    chk("fullrw_count", 64'(count), 64'd8);
    chk("fullrw_overrun", 64'(overrun), 64'd0);
    repeat (7) step(1'b0, 32'h0, 5'h0, 1'b1, 1'b0);
    chk("fullrw_last", 64'(out_z), 64'h4040_0000);
    step(1'b0, 32'h0, 5'h0, 1'b1, 1'b0);

    // Sticky flags and clear-with-write
    step(1'b1, 32'h3F80_0000, 5'b00010, 1'b1, 1'b0);
    step(1'b1, 32'h7FC0_0000, 5'b10000, 1'b1, 1'b0);
    chk("sticky_or", 64'(sticky_flags), 64'b10010);
    step(1'b1, 32'h0000_0001, 5'b00001, 1'b1, 1'b1);
    chk("sticky_clr_wr", 64'(sticky_flags), 64'b00001);
    step(1'b0, 32'h0, 5'h0, 1'b1, 1'b0);

    // Reset mid-operation
    for (int i = 0; i < 9; i++) step(1'b1, 32'h4200_0000 + 32'(i), 5'b00100, 1'b0, 1'b0);
    repeat (3) step(1'b0, 32'h0, 5'h0, 1'b1, 1'b0);
    chk("mid_count", 64'(count), 64'd5);
    chk("mid_overrun", 64'(overrun), 64'd1);
    do_reset(1);
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_overrun", 64'(overrun), 64'd0);
    chk("mid_rst_sticky", 64'(sticky_flags), 64'd0);
    step(1'b1, 32'h3F80_0000, 5'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 5'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 5'h0, 1'b1, 1'b0);

    // Randomized interleaving with pointer wrap
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 32'hC0DE_0000 | 32'(i), 5'($urandom),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < 120; i++) begin
      step(1'($urandom_range(0, 3) != 0), 32'hBEEF_0000 | 32'(i), 5'($urandom),
           1'($urandom_range(0, 1)), 1'b0);
    end
    repeat (10) step(1'b0, 32'h0, 5'h0, 1'b1, 1'b0);
    chk("final_count", 64'(count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
